weather_classification_system: RTL and testbench

- Decodes a 40-bit DHT11/DHT22-style sensor frame {hum_int, hum_dec, temp_int, temp_dec, checksum} and verifies the 8-bit checksum.
- Publishes registered humidity/temperature fields, a valid flag and a 3-bit weather class.
- Sits downstream of the DHT serial receiver and feeds display/reporting logic.

---
 rtl/weather_pkg.sv | 21 ++
 rtl/weather_classifier.sv | 36 +++
 rtl/weather_classification_system.sv | 80 ++++++++
 tb/tb_weather_classification_system.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/weather_pkg.sv
// rtl/weather_pkg.sv - class encodings and sensor frame field positions
package weather_pkg;

  localparam logic [2:0] CLS_NONE     = 3'd0;
  localparam logic [2:0] CLS_COLD     = 3'd1;
  localparam logic [2:0] CLS_WARM     = 3'd2;
  localparam logic [2:0] CLS_HOT      = 3'd3;
  localparam logic [2:0] CLS_HUMID    = 3'd4;
  localparam logic [2:0] CLS_RAIN     = 3'd5;
  localparam logic [2:0] CLS_PLEASANT = 3'd6;
  localparam logic [2:0] CLS_ERROR    = 3'd7;

  localparam int FRAME_W      = 40;
  localparam int FIELD_W      = 8;
  localparam int HUM_INT_LSB  = 32;
  localparam int HUM_DEC_LSB  = 24;
  localparam int TEMP_INT_LSB = 16;
  localparam int TEMP_DEC_LSB = 8;
  localparam int CSUM_LSB     = 0;

endpackage

// File: rtl/weather_classifier.sv
// rtl/weather_classifier.sv - priority classification of humidity/temperature integers
module weather_classifier
  import weather_pkg::*;
#(
  parameter logic [7:0] HUM_RAIN  = 8'd85,
  parameter logic [7:0] HUM_HUMID = 8'd70,
  parameter logic [7:0] TEMP_HOT  = 8'd30,
  parameter logic [7:0] TEMP_WARM = 8'd25,
  parameter logic [7:0] TEMP_COLD = 8'd15,
  parameter logic [7:0] HUM_MAX   = 8'd100,
  parameter logic [7:0] TEMP_MAX  = 8'd50
) (
  input  logic [7:0] hum_int,
  input  logic [7:0] temp_int,
  output logic [2:0] weather_class
);

  // Out-of-range beats humidity, humidity beats temperature; pleasant is the fallthrough
  always_comb begin
    weather_class = CLS_PLEASANT;
    if (hum_int > HUM_MAX || temp_int > TEMP_MAX) begin
      weather_class = CLS_ERROR;
    end else if (hum_int >= HUM_RAIN) begin
      weather_class = CLS_RAIN;
    end else if (hum_int >= HUM_HUMID) begin
      weather_class = CLS_HUMID;
    end else if (temp_int >= TEMP_HOT) begin
      weather_class = CLS_HOT;
    end else if (temp_int >= TEMP_WARM) begin
      weather_class = CLS_WARM;
    end else if (temp_int < TEMP_COLD) begin
      weather_class = CLS_COLD;
    end
  end

endmodule

// File: rtl/weather_classification_system.sv
// rtl/weather_classification_system.sv - checksum-verified sensor frame decode and weather class register
module weather_classification_system
  import weather_pkg::*;
#(
  parameter logic [7:0] HUM_RAIN  = 8'd85,
  parameter logic [7:0] HUM_HUMID = 8'd70,
  parameter logic [7:0] TEMP_HOT  = 8'd30,
  parameter logic [7:0] TEMP_WARM = 8'd25,
  parameter logic [7:0] TEMP_COLD = 8'd15,
  parameter logic [7:0] HUM_MAX   = 8'd100,
  parameter logic [7:0] TEMP_MAX  = 8'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] dht_frame,
  output logic [7:0]  hum_int,
  output logic [7:0]  hum_dec,
  output logic [7:0]  temp_int,
  output logic [7:0]  temp_dec,
  output logic        valid,
  output logic [2:0]  class_out
);

  logic [7:0] f_hum_int;
  logic [7:0] f_hum_dec;
  logic [7:0] f_temp_int;
  logic [7:0] f_temp_dec;
  logic [7:0] f_csum;
  logic [7:0] sum;
  logic       frame_good;
  logic [2:0] frame_class;

  assign f_hum_int  = dht_frame[HUM_INT_LSB  +: FIELD_W];
  assign f_hum_dec  = dht_frame[HUM_DEC_LSB  +: FIELD_W];
  assign f_temp_int = dht_frame[TEMP_INT_LSB +: FIELD_W];
  assign f_temp_dec = dht_frame[TEMP_DEC_LSB +: FIELD_W];
  assign f_csum     = dht_frame[CSUM_LSB     +: FIELD_W];

  // 8-bit sum wraps naturally, matching the sensor's mod-256 checksum
  assign sum        = f_hum_int + f_hum_dec + f_temp_int + f_temp_dec;
  assign frame_good = (sum == f_csum);

  // Classify the incoming frame so the class registers alongside its own fields
  weather_classifier #(
    .HUM_RAIN  (HUM_RAIN),
    .HUM_HUMID (HUM_HUMID),
    .TEMP_HOT  (TEMP_HOT),
    .TEMP_WARM (TEMP_WARM),
    .TEMP_COLD (TEMP_COLD),
    .HUM_MAX   (HUM_MAX),
    .TEMP_MAX  (TEMP_MAX)
  ) u_classifier (
    .hum_int       (f_hum_int),
    .temp_int      (f_temp_int),
    .weather_class (frame_class)
  );

  // Good frames load fields and class; bad frames keep fields and report NONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hum_int   <= '0;
      hum_dec   <= '0;
      temp_int  <= '0;
      temp_dec  <= '0;
      valid     <= 1'b0;
      class_out <= CLS_NONE;
    end else if (frame_good) begin
      hum_int   <= f_hum_int;
      hum_dec   <= f_hum_dec;
      temp_int  <= f_temp_int;
      temp_dec  <= f_temp_dec;
      valid     <= 1'b1;
      class_out <= frame_class;
    end else begin
      valid     <= 1'b0;
      class_out <= CLS_NONE;
    end
  end

endmodule

// File: tb/tb_weather_classification_system.sv
// tb/tb_weather_classification_system.sv - scoreboard bench for the weather classification system
module tb_weather_classification_system;

  logic        clk;
  logic        rst;
  logic [39:0] dht_frame;
  logic [7:0]  hum_int;
  logic [7:0]  hum_dec;
  logic [7:0]  temp_int;
  logic [7:0]  temp_dec;
  logic        valid;
  logic [2:0]  class_out;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] hd;
    logic [7:0] ti;
    logic [7:0] td;
    logic       v;
    logic [2:0] c;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  logic [7:0] m_hi, m_hd, m_ti, m_td;

  weather_classification_system dut (
    .clk       (clk),
    .rst       (rst),
    .dht_frame (dht_frame),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .temp_int  (temp_int),
    .temp_dec  (temp_dec),
    .valid     (valid),
    .class_out (class_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] mk(int h, int hd, int t, int td, int cs);
    logic [7:0] a, b, c, d, e;
    a = h[7:0]; b = hd[7:0]; c = t[7:0]; d = td[7:0]; e = cs[7:0];
    return {a, b, c, d, e};
  endfunction

  function automatic logic [2:0] ref_class(int h, int t);
    if (h > 100 || t > 50) return 3'd7;
    if (h >= 85) return 3'd5;
    if (h >= 70) return 3'd4;
    if (t >= 30) return 3'd3;
    if (t >= 25) return 3'd2;
    if (t < 15) return 3'd1;
    return 3'd6;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.tag, ".hum_int"},   hum_int,  e.hi);
    chk({e.tag, ".hum_dec"},   hum_dec,  e.hd);
    chk({e.tag, ".temp_int"},  temp_int, e.ti);
    chk({e.tag, ".temp_dec"},  temp_dec, e.td);
    chk({e.tag, ".valid"},     {7'd0, valid},     {7'd0, e.v});
    chk({e.tag, ".class_out"}, {5'd0, class_out}, {5'd0, e.c});
  endtask

  function automatic exp_t zero_exp(input string tag);
    exp_t e;
    e.hi = 0; e.hd = 0; e.ti = 0; e.td = 0; e.v = 1'b0; e.c = 3'd0; e.tag = tag;
    return e;
  endfunction

  // Called just after a rising edge: drive frame, predict, sample one edge later
  task automatic step(input string tag, input logic [39:0] f);
    exp_t e;
    int   s;
    dht_frame = f;
    s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    if (s == int'(f[7:0])) begin
      m_hi = f[39:32]; m_hd = f[31:24]; m_ti = f[23:16]; m_td = f[15:8];
      e.v = 1'b1;
      e.c = ref_class(int'(f[39:32]), int'(f[23:16]));
    end else begin
      e.v = 1'b0;
      e.c = 3'd0;
    end
    e.hi = m_hi; e.hd = m_hd; e.ti = m_ti; e.td = m_td; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
    end
    if (exp_q.size() > 0) check_outputs(exp_q.pop_front());
  endtask

  initial begin
    logic [39:0] f;
    int h, hd, t, td, cs;
    checks = 0;
    errors = 0;
    m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0;

    rst = 1'b0;
    dht_frame = mk(45, 0, 20, 0, 65);
    repeat (2) @(posedge clk);
    #1;
    check_outputs(zero_exp("reset"));

    rst = 1'b1;
    step("first_after_reset", mk(45, 0, 20, 0, 65));
    step("warm",     mk(47, 0, 27, 0, 74));
    step("humid",    mk(81, 7, 25, 24, 137));
    step("rain",     mk(87, 49, 20, 21, 177));
    step("wrap_err", mk(200, 50, 40, 10, 44));
    step("good_pre", mk(45, 0, 20, 0, 65));
    step("bad_csum", mk(60, 0, 10, 0, 99));
    step("t15",      mk(30, 0, 15, 0, 45));
    step("t14",      mk(30, 0, 14, 0, 44));
    step("t30",      mk(30, 0, 30, 0, 60));
    step("h85",      mk(85, 0, 10, 0, 95));
    step("h84",      mk(84, 0, 10, 0, 94));
    step("h70",      mk(70, 0, 40, 0, 110));
    step("t25",      mk(30, 0, 25, 0, 55));
    step("h100",     mk(100, 0, 20, 0, 120));
    step("h101",     mk(101, 0, 20, 0, 121));
    step("t51",      mk(30, 0, 51, 0, 81));
    step("hold0",    mk(81, 7, 25, 24, 137));
    step("hold1",    mk(81, 7, 25, 24, 137));
    step("hold2",    mk(81, 7, 25, 24, 137));

    #3;
    rst = 1'b0;
    #1;
    check_outputs(zero_exp("async_reset"));
    m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0;
    @(posedge clk);
    #1;
    check_outputs(zero_exp("reset_held"));
    rst = 1'b1;
    step("after_midreset", mk(47, 0, 27, 0, 74));

    for (int i = 0; i < 40; i++) begin
      h  = $urandom_range(0, 120);
      hd = $urandom_range(0, 99);
      t  = $urandom_range(0, 60);
      td = $urandom_range(0, 99);
      cs = (h + hd + t + td) % 256;
      if ($urandom_range(0, 3) == 0) cs = (cs + $urandom_range(1, 255)) % 256;
      f = mk(h, hd, t, td, cs);
      step($sformatf("rand%0d", i), f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
